// File: rtl/gpio_pkg.sv
// Shared register map and decode helpers for the GPIO bank.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gpio_pkg;

    localparam logic [5:0] GPIO_OE   = 6'h00;
    localparam logic [5:0] GPIO_OUT  = 6'h04;
    localparam logic [5:0] GPIO_IN   = 6'h08;
    localparam logic [5:0] GPIO_SET  = 6'h0C;
    localparam logic [5:0] GPIO_CLR  = 6'h10;
    localparam logic [5:0] GPIO_TGL  = 6'h14;
    localparam logic [5:0] GPIO_IE   = 6'h18;
    localparam logic [5:0] GPIO_RISE = 6'h1C;
    localparam logic [5:0] GPIO_IS   = 6'h20;

    typedef enum logic [3:0] {
        REG_OE,
        REG_OUT,
        REG_IN,
        REG_SET,
        REG_CLR,
        REG_TGL,
        REG_IE,
        REG_RISE,
        REG_IS,
        REG_NONE
    } reg_sel_e;

    // Byte-address decode; the low two address bits never select a register.
    function automatic reg_sel_e decode(input logic [5:0] addr);
        case (addr & 6'h3C)
            GPIO_OE:   return REG_OE;
            GPIO_OUT:  return REG_OUT;
            GPIO_IN:   return REG_IN;
            GPIO_SET:  return REG_SET;
            GPIO_CLR:  return REG_CLR;
            GPIO_TGL:  return REG_TGL;
            GPIO_IE:   return REG_IE;
            GPIO_RISE: return REG_RISE;
            GPIO_IS:   return REG_IS;
            default:   return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Single-bit pad input synchroniser, SYNC_STAGES flops deep.
// Latency: SYNC_STAGES clk cycles from d to q.
// Backpressure: none, samples every cycle.
module gpio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: OE/OUT/IN registers, set/clear/toggle aliases, edge-detect interrupts.
// Latency: ready and rdata one cycle after the accepting cycle; irq one cycle after IS.
// Backpressure: one request per valid assertion; valid must drop before the next is taken.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       addr,
    input  logic [3:0]       wrstb,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] is_q;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_dly;
    logic             done_q;

    logic             accept;
    logic             wr_en;
    logic             rd_en;
    reg_sel_e         sel;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_val;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        gpio_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .resetn(resetn),
            .d     (gpio_in[i]),
            .q     (in_sync[i])
        );
    end

    // done_q holds off re-acceptance while the master keeps valid high after ready.
    assign accept = valid && !ready && !done_q;
    assign wr_en  = accept && (wrstb != 4'h0);
    assign rd_en  = accept && (wrstb == 4'h0);
    assign sel    = decode(addr);
    assign wmask  = WIDTH'(lane_mask(wrstb));
    assign wd     = WIDTH'(wdata);
    assign wbits  = wd & wmask;

    assign rise_ev  = in_sync & ~in_dly;
    assign fall_ev  = ~in_sync & in_dly;
    assign edge_hit = ((rise_ev & rise_q) | (fall_ev & ~rise_q)) & ie_q;
    assign w1c      = (wr_en && sel == REG_IS) ? wbits : '0;

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_OE:   rd_val[WIDTH-1:0] = oe_q;
            REG_OUT:  rd_val[WIDTH-1:0] = out_q;
            REG_IN:   rd_val[WIDTH-1:0] = in_sync;
            REG_IE:   rd_val[WIDTH-1:0] = ie_q;
            REG_RISE: rd_val[WIDTH-1:0] = rise_q;
            REG_IS:   rd_val[WIDTH-1:0] = is_q;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oe_q   <= '0;
            out_q  <= '0;
            ie_q   <= '0;
            rise_q <= '1;
            is_q   <= '0;
            in_dly <= '0;
            done_q <= 1'b0;
            ready  <= 1'b0;
            rdata  <= '0;
            irq    <= 1'b0;
        end else begin
            ready  <= accept;
            done_q <= valid && (done_q || accept);
            in_dly <= in_sync;
            irq    <= |(is_q & ie_q);
            // A fresh edge in the same cycle as a W1C keeps the bit set.
            is_q   <= (is_q & ~w1c) | edge_hit;
            if (rd_en) begin
                rdata <= rd_val;
            end
            if (wr_en) begin
                case (sel)
                    REG_OE:   oe_q   <= (oe_q & ~wmask) | wbits;
                    REG_OUT:  out_q  <= (out_q & ~wmask) | wbits;
                    REG_SET:  out_q  <= out_q | wbits;
                    REG_CLR:  out_q  <= out_q & ~wbits;
                    REG_TGL:  out_q  <= out_q ^ wbits;
                    REG_IE:   ie_q   <= (ie_q & ~wmask) | wbits;
                    REG_RISE: rise_q <= (rise_q & ~wmask) | wbits;
                    default:  ;
                endcase
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: an 8-bit and a 16-bit instance share one request bus;
// read responses are checked by a monitor against queued expectations.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  addr;
    logic [3:0]  wrstb;
    logic [31:0] wdata;
    logic        valid;
    logic [7:0]  gpio_in;
    logic [15:0] gpio_in_b;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b;
    logic [7:0]  gpio_out_a, gpio_oe_a;
    logic [15:0] gpio_out_b, gpio_oe_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    string       q_n[$];
    logic        mon_rd = 1'b0;

    assign gpio_in_b = {8'h00, gpio_in};

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .resetn(resetn), .addr(addr), .wrstb(wrstb), .wdata(wdata),
        .rdata(rdata_a), .valid(valid), .ready(ready_a), .gpio_in(gpio_in),
        .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a), .irq(irq_a)
    );

    gpio_bank #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .resetn(resetn), .addr(addr), .wrstb(wrstb), .wdata(wdata),
        .rdata(rdata_b), .valid(valid), .ready(ready_b), .gpio_in(gpio_in_b),
        .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b), .irq(irq_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remember whether the request being accepted is a read.
    always @(posedge clk) begin
        if (valid && !ready_a) mon_rd = (wrstb == 4'h0);
    end

    always @(negedge clk) begin
        if (ready_a && mon_rd) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected no response", rdata_a);
            end else begin
                string n;
                n = q_n.pop_front();
                chk({n, "_w8"}, rdata_a, q_a.pop_front());
                chk({n, "_w16"}, rdata_b, q_b.pop_front());
                chk({n, "_rdy16"}, {31'b0, ready_b}, 32'd1);
            end
        end
    end

    task automatic bus(input logic [5:0] a, input logic [3:0] s, input logic [31:0] d);
        int n;
        @(negedge clk);
        addr = a; wrstb = s; wdata = d; valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready_a && n < 20);
        chk("bus_ready", {31'b0, ready_a}, 32'd1);
        valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e8, input logic [31:0] e16,
                      input string name);
        q_a.push_back(e8);
        q_b.push_back(e16);
        q_n.push_back(name);
        bus(a, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        resetn = 1'b0; valid = 1'b0; addr = '0; wrstb = '0; wdata = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        #1;
        chk("rst_oe", {24'b0, gpio_oe_a}, 32'h0);
        chk("rst_out", {24'b0, gpio_out_a}, 32'h0);
        chk("rst_irq", {31'b0, irq_a}, 32'h0);
        chk("rst_ready", {31'b0, ready_a}, 32'h0);
        rd(GPIO_RISE, 32'h0000_00FF, 32'h0000_FFFF, "rst_rise");
        rd(GPIO_IS, 32'h0, 32'h0, "rst_is");
        rd(GPIO_IN, 32'h0, 32'h0, "rst_in");
        rd(6'h24, 32'h0, 32'h0, "unmapped");

        bus(GPIO_OUT, 4'hF, 32'h0000_00A5);
        rd(GPIO_OUT, 32'hA5, 32'hA5, "out_wr");
        bus(GPIO_SET, 4'hF, 32'h0000_000A);
        rd(GPIO_OUT, 32'hAF, 32'hAF, "out_set");
        bus(GPIO_CLR, 4'hF, 32'h0000_0081);
        rd(GPIO_OUT, 32'h2E, 32'h2E, "out_clr");
        bus(GPIO_TGL, 4'hF, 32'h0000_00FF);
        rd(GPIO_OUT, 32'hD1, 32'hD1, "out_tgl");
        rd(GPIO_SET, 32'h0, 32'h0, "set_reads_zero");
        chk("pin_out_w8", {24'b0, gpio_out_a}, 32'hD1);
        chk("pin_out_w16", {16'b0, gpio_out_b}, 32'h00D1);
        bus(GPIO_IN, 4'hF, 32'hFFFF_FFFF);
        rd(GPIO_IN, 32'h0, 32'h0, "in_write_ignored");

        bus(GPIO_OE, 4'h1, 32'h0000_1234);
        rd(GPIO_OE, 32'h34, 32'h0034, "oe_lane0");
        bus(GPIO_OE, 4'h3, 32'h0000_5678);
        rd(GPIO_OE, 32'h78, 32'h5678, "oe_lanes01");
        chk("pin_oe_w8", {24'b0, gpio_oe_a}, 32'h78);
        chk("pin_oe_w16", {16'b0, gpio_oe_b}, 32'h5678);

        bus(GPIO_IE, 4'hF, 32'h1);
        bus(GPIO_RISE, 4'hF, 32'h1);
        @(negedge clk) gpio_in[0] = 1'b1;
        n = 0;
        while (!irq_a && n < SYNC + 2) begin
            @(posedge clk); #1;
            n++;
        end
        chk("irq_rise_w8", {31'b0, irq_a}, 32'd1);
        chk("irq_rise_w16", {31'b0, irq_b}, 32'd1);
        rd(GPIO_IN, 32'h01, 32'h0001, "in_sync");
        rd(GPIO_IS, 32'h01, 32'h0001, "is_rise");
        bus(GPIO_IS, 4'hF, 32'h1);
        chk("irq_w1c", {31'b0, irq_a}, 32'h0);
        rd(GPIO_IS, 32'h0, 32'h0, "is_cleared");

        @(negedge clk) gpio_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        rd(GPIO_IS, 32'h0, 32'h0, "fall_ignored");
        @(negedge clk) gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("irq_second_rise", {31'b0, irq_a}, 32'd1);
        gpio_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        // The W1C below is accepted on the same edge that the new rise sets IS.
        gpio_in[0] = 1'b1;
        @(negedge clk);
        bus(GPIO_IS, 4'hF, 32'h1);
        chk("irq_set_wins", {31'b0, irq_a}, 32'd1);
        rd(GPIO_IS, 32'h01, 32'h0001, "is_set_wins");

        @(negedge clk);
        addr = GPIO_TGL; wrstb = 4'hF; wdata = 32'h0F; valid = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready_a) cnt++;
        end
        valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ready_a) cnt++;
        end
        chk("hold_one_ready", cnt, 32'd1);
        rd(GPIO_OUT, 32'hDE, 32'hDE, "hold_one_toggle");

        @(negedge clk);
        addr = GPIO_TGL; wrstb = 4'hF; wdata = 32'hFF; valid = 1'b1;
        #2 resetn = 1'b0;
        @(posedge clk); #1 valid = 1'b0;
        @(negedge clk) resetn = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready_a) cnt++;
        end
        chk("rst_drop_ready", cnt, 32'd0);
        chk("rst2_oe", {24'b0, gpio_oe_a}, 32'h0);
        chk("rst2_out", {16'b0, gpio_out_b}, 32'h0);
        chk("rst2_irq", {31'b0, irq_a}, 32'h0);
        rd(GPIO_OUT, 32'h0, 32'h0, "rst2_out_rd");
        rd(GPIO_OE, 32'h0, 32'h0, "rst2_oe_rd");
        rd(GPIO_IE, 32'h0, 32'h0, "rst2_ie_rd");
        rd(GPIO_IS, 32'h0, 32'h0, "rst2_is_rd");
        rd(GPIO_RISE, 32'h0000_00FF, 32'h0000_FFFF, "rst2_rise_rd");

        repeat (2) @(posedge clk);
        chk("queue_drained", q_a.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-003 SHALL have ports clk input 1 (system clock) and resetn input 1 (reset, asynchronous, active-low), listed first.
REQ-004 SHALL have port addr input 6 (byte address; bits [1:0] ignored).
REQ-005 SHALL have port wrstb input 4 (byte write strobes; all zero means read).
REQ-006 SHALL have port wdata input 32 (write data).
REQ-007 SHALL have port rdata output 32 (registered read data).
REQ-008 SHALL have port valid input 1 (request); ready output 1 (one-cycle completion pulse).
REQ-009 SHALL have ports gpio_in input WIDTH (pad inputs, asynchronous), gpio_out output WIDTH (pad outputs), gpio_oe output WIDTH (pad output enables).
REQ-010 SHALL have port irq output 1 (level interrupt).

Function
REQ-011 SHALL assert ready for exactly one cycle, one cycle after valid is sampled high while ready is low; the master holds valid until ready.
REQ-012 SHALL perform a write or read-capture only on the accepting cycle (valid && !ready), so each request acts exactly once.
REQ-013 SHALL apply writes per byte lane: register bits [8k+7:8k] change only when wrstb[k]=1; bits at or above WIDTH are ignored.
REQ-014 SHALL decode registers: 0x00 OE rw; 0x04 OUT rw; 0x08 IN ro; 0x0C SET wo (OUT |= wdata); 0x10 CLR wo (OUT &= ~wdata); 0x14 TGL wo (OUT ^= wdata); 0x18 IE rw; 0x1C RISE rw (1 = rising, 0 = falling edge); 0x20 IS rw1c.
REQ-015 SHALL return zero-extended register contents on reads; write-only and unmapped addresses read 0; writes to IN or unmapped addresses are ignored.
REQ-016 SHALL pass gpio_in through a SYNC_STAGES flop chain per bit; IN reads the final stage; latency from pad to IN is SYNC_STAGES cycles.
REQ-017 SHALL detect edges by comparing the final sync stage with a one-cycle-delayed copy; IS[i] sets when the selected edge occurs on bit i and IE[i]=1.
REQ-018 SHALL, when a W1C to IS and a new edge on the same bit coincide, leave that bit set (set wins).
REQ-019 SHALL drive irq = |(IS & IE), registered, so irq follows IS with one cycle of latency.
REQ-020 SHALL drive gpio_out from OUT and gpio_oe from OE directly; OUT remains in effect even while OE=0.
REQ-021 SHALL update the edge-detect delay flop regardless of IE, so enabling IE never reports a stale edge.

Reset
REQ-022 SHALL, on resetn low, asynchronously clear OE, OUT, IE, IS, rdata, ready, irq and all sync/delay flops to 0, and set RISE to all ones.
REQ-023 SHALL drop any request that is in flight at reset; no ready pulse follows the deasserted reset for that request.

Structure
REQ-024 SHALL take register offsets (GPIO_OE ... GPIO_IS) from the shared package gpio_pkg.
REQ-025 SHALL isolate the per-bit synchroniser in one sub-module, gpio_sync, parameterised by SYNC_STAGES.

Verification
REQ-026 SHALL cover: reset -> gpio_oe=0, gpio_out=0, irq=0, read 0x1C returns 0x000000FF (WIDTH=8).
REQ-027 SHALL cover: write OUT=0xA5 with wrstb=0xF, then SET 0x0A, CLR 0x81, TGL 0xFF -> OUT reads 0xA5, 0xAF, 0x2E, 0xD1.
REQ-028 SHALL cover: write OE=0x1234 with wrstb=0x1 and WIDTH=16 -> OE reads 0x0034.
REQ-029 SHALL cover: IE=0x01, RISE=0x01, gpio_in[0] goes 0->1 -> IS reads 0x01 and irq=1 within SYNC_STAGES+2 cycles; write IS=0x01 -> irq=0 on the following cycle.
REQ-030 SHALL cover: a W1C to IS in the same cycle as a new rising edge on bit 0 -> IS[0] stays 1 and irq stays 1.
REQ-031 SHALL cover: valid held for 5 cycles on a TGL write -> one ready pulse and one toggle; resetn pulsed low mid-request -> no ready pulse and all registers at reset values.
